// File: rtl/memory_pkg.sv
// Shared widths and defaults for the memory/writeback stage.
// Configuration: the MEM_MMIO_EN macro enables the debug-port store address.
package memory_pkg;

    localparam int          WORD_W      = 32;
    localparam int          REG_W       = 5;
    localparam int          DMEM_DEPTH  = 1024;
    localparam logic [31:0] MMIO_ADDR_D = 32'hFFFF_FFF0;

    // Destination x0 is hard-wired to zero, so a write to it never reaches the register file.
    function automatic logic reg_write_eff(input logic reg_write, input logic [REG_W-1:0] idx);
        return reg_write && (idx != '0);
    endfunction

endpackage

// File: rtl/memory_dmem.sv
// Data memory: DEPTH words, synchronous write, asynchronous read.
// Read of a just-written word returns the new data on the following cycle.
module memory_dmem
    import memory_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory.sv
// Memory/writeback stage: data-memory access, result mux, and the M/W register (1-cycle latency).
// No stall or flush; MEM_MMIO_EN adds the dbgOut port written by stores to MMIO_ADDR.
module memory
    import memory_pkg::*;
#(
    parameter int          DEPTH     = DMEM_DEPTH,
    parameter int          ADDR_BITS = $clog2(DEPTH),
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] ALUResultM,
    input  logic [WORD_W-1:0] writeDataM,
    input  logic [REG_W-1:0]  writeRegM,
    input  logic [WORD_W-1:0] pcM,
    input  logic              zeroM,
    input  logic              regWriteM,
    input  logic              memWriteM,
    input  logic              mem2regM,
    output logic              regWriteW,
    output logic [REG_W-1:0]  writeRegW,
    output logic [WORD_W-1:0] resultW,
    output logic [WORD_W-1:0] pcW,
`ifdef MEM_MMIO_EN
    output logic [WORD_W-1:0] dbgOut,
`endif
    output logic              zeroW
);

    logic [ADDR_BITS-1:0] word_idx;
    logic [WORD_W-1:0]    mem_rdata;
    logic [WORD_W-1:0]    read_data;
    logic [WORD_W-1:0]    result_m;
    logic                 mem_we;

    // Byte offset and bits above the array are discarded: addresses wrap modulo DEPTH*4.
    assign word_idx = ALUResultM[ADDR_BITS+1:2];

`ifdef MEM_MMIO_EN
    logic mmio_hit;
    assign mmio_hit  = (ALUResultM == MMIO_ADDR);
    assign mem_we    = memWriteM && !reset && !mmio_hit;
    assign read_data = mmio_hit ? dbgOut : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            dbgOut <= '0;
        end else if (memWriteM && mmio_hit) begin
            dbgOut <= writeDataM;
        end
    end
`else
    logic [WORD_W-1:0] unused_mmio;
    logic              unused_addr_bits;
    assign unused_mmio      = MMIO_ADDR;
    assign unused_addr_bits = ^{ALUResultM[WORD_W-1:ADDR_BITS+2], ALUResultM[1:0], unused_mmio};
    assign mem_we           = memWriteM && !reset;
    assign read_data        = mem_rdata;
`endif

    memory_dmem #(
        .DEPTH    (DEPTH),
        .ADDR_BITS(ADDR_BITS)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .addr (word_idx),
        .wdata(writeDataM),
        .rdata(mem_rdata)
    );

    // Mux ahead of the register; a store+load pair sees the pre-store word here.
    assign result_m = mem2regM ? read_data : ALUResultM;

    always_ff @(posedge clk) begin
        if (reset) begin
            regWriteW <= 1'b0;
            writeRegW <= '0;
            resultW   <= '0;
            pcW       <= '0;
            zeroW     <= 1'b0;
        end else begin
            regWriteW <= reg_write_eff(regWriteM, writeRegM);
            writeRegW <= writeRegM;
            resultW   <= result_m;
            pcW       <= pcM;
            zeroW     <= zeroM;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed-vector bench for the memory/writeback stage; define MEM_MMIO_EN to cover the debug port.
module tb_memory;
    import memory_pkg::*;

    typedef struct packed {
        logic        rst;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [31:0] pc;
        logic        zero;
        logic        regw;
        logic        memw;
        logic        m2r;
        logic        e_regw;
        logic [4:0]  e_wreg;
        logic [31:0] e_res;
        logic [31:0] e_pc;
        logic        e_zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, writeDataM, pcM;
    logic [4:0]  writeRegM;
    logic        zeroM, regWriteM, memWriteM, mem2regM;
    logic        regWriteW, zeroW;
    logic [4:0]  writeRegW;
    logic [31:0] resultW, pcW;
`ifdef MEM_MMIO_EN
    logic [31:0] dbgOut;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResultM(ALUResultM),
        .writeDataM(writeDataM),
        .writeRegM (writeRegM),
        .pcM       (pcM),
        .zeroM     (zeroM),
        .regWriteM (regWriteM),
        .memWriteM (memWriteM),
        .mem2regM  (mem2regM),
        .regWriteW (regWriteW),
        .writeRegW (writeRegW),
        .resultW   (resultW),
        .pcW       (pcW),
`ifdef MEM_MMIO_EN
        .dbgOut    (dbgOut),
`endif
        .zeroW     (zeroW)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        ALUResultM = v.alu;
        writeDataM = v.wdata;
        writeRegM  = v.wreg;
        pcM        = v.pc;
        zeroM      = v.zero;
        regWriteM  = v.regw;
        memWriteM  = v.memw;
        mem2regM   = v.m2r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        check({tag, ".regWriteW"}, {31'd0, regWriteW}, {31'd0, v.e_regw});
        check({tag, ".writeRegW"}, {27'd0, writeRegW}, {27'd0, v.e_wreg});
        check({tag, ".resultW"},   resultW,            v.e_res);
        check({tag, ".pcW"},       pcW,                v.e_pc);
        check({tag, ".zeroW"},     {31'd0, zeroW},     {31'd0, v.e_zero});
    endtask

    vec_t vecs[12];
    vec_t rv;

    initial begin
        //          rst alu           wdata         wreg pc     z  rw mw m2r | e_rw e_wr e_res         e_pc   e_z
        vecs[0]  = '{0, 32'h1234,     32'h0,        5,  32'h0,  0, 1, 0, 0,    1,   5,  32'h1234,     32'h0,  0};
        vecs[1]  = '{0, 32'h40,       32'hDEADBEEF, 0,  32'h4,  1, 0, 1, 0,    0,   0,  32'h40,       32'h4,  1};
        vecs[2]  = '{0, 32'h40,       32'h0,        7,  32'h8,  0, 1, 0, 1,    1,   7,  32'hDEADBEEF, 32'h8,  0};
        vecs[3]  = '{0, 32'h43,       32'hA5A5A5A5, 0,  32'hC,  0, 0, 1, 0,    0,   0,  32'h43,       32'hC,  0};
        vecs[4]  = '{0, 32'h40,       32'h0,        9,  32'h10, 0, 1, 0, 1,    1,   9,  32'hA5A5A5A5, 32'h10, 0};
        vecs[5]  = '{0, 32'h1040,     32'h0,        10, 32'h14, 0, 1, 0, 1,    1,   10, 32'hA5A5A5A5, 32'h14, 0};
        vecs[6]  = '{0, 32'h99,       32'h0,        0,  32'h18, 1, 1, 0, 0,    0,   0,  32'h99,       32'h18, 1};
        vecs[7]  = '{0, 32'h80,       32'h77,       0,  32'h1C, 0, 0, 1, 0,    0,   0,  32'h80,       32'h1C, 0};
        vecs[8]  = '{1, 32'h80,       32'h11,       4,  32'h20, 1, 1, 1, 0,    0,   0,  32'h0,        32'h0,  0};
        vecs[9]  = '{0, 32'h80,       32'h0,        11, 32'h24, 0, 1, 0, 1,    1,   11, 32'h77,       32'h24, 0};
        vecs[10] = '{0, 32'h40,       32'h12345678, 12, 32'h28, 0, 1, 1, 1,    1,   12, 32'hA5A5A5A5, 32'h28, 0};
        vecs[11] = '{0, 32'h40,       32'h0,        13, 32'h2C, 1, 1, 0, 1,    1,   13, 32'h12345678, 32'h2C, 1};

        // Reset held two cycles under arbitrary M inputs; every W output must read zero.
        for (int i = 0; i < 2; i++) begin
            rv       = '0;
            rv.rst   = 1'b1;
            rv.alu   = $urandom;
            rv.wdata = $urandom;
            rv.wreg  = 5'($urandom_range(1, 31));
            rv.pc    = $urandom;
            rv.zero  = 1'b1;
            rv.regw  = 1'b1;
            rv.memw  = 1'($urandom_range(0, 1));
            rv.m2r   = 1'($urandom_range(0, 1));
            run_vec($sformatf("reset%0d", i), rv);
`ifdef MEM_MMIO_EN
            check("reset.dbgOut", dbgOut, 32'h0);
`endif
        end

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // High address: aliases index 0x3FC, or is the debug port when enabled.
        run_vec("alias_st", '{0, 32'hFF0, 32'h5555, 0, 32'h30, 0, 0, 1, 0,
                               0, 0, 32'hFF0, 32'h30, 0});
        run_vec("mmio_st", '{0, 32'hFFFF_FFF0, 32'hCAFEF00D, 0, 32'h34, 0, 0, 1, 0,
                              0, 0, 32'hFFFF_FFF0, 32'h34, 0});
`ifdef MEM_MMIO_EN
        check("mmio_st.dbgOut", dbgOut, 32'hCAFEF00D);
        run_vec("mmio_ld", '{0, 32'hFFFF_FFF0, 32'h0, 14, 32'h38, 0, 1, 0, 1,
                              1, 14, 32'hCAFEF00D, 32'h38, 0});
        run_vec("alias_ld", '{0, 32'hFF0, 32'h0, 15, 32'h3C, 0, 1, 0, 1,
                               1, 15, 32'h5555, 32'h3C, 0});
`else
        run_vec("alias_ld", '{0, 32'hFF0, 32'h0, 15, 32'h3C, 0, 1, 0, 1,
                               1, 15, 32'hCAFEF00D, 32'h3C, 0});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
